// File: rtl/ib_rom_rd_arbiter.sv
// IB-ROM read-port arbiter: grants CN or VN requesters fixed-length page
// bursts on a single ROM port, with round-robin tie-break and range checking.

module ib_rom_rd_arbiter #(
    parameter int ITER_ADDR_BW = 5,
    parameter int PAGE_ADDR_BW = 5,
    parameter int ROM_ADDR_BW  = 10,
    parameter int BURST_LEN    = 32,
    parameter int MAX_ITER     = 25
) (
    input  logic                    write_clk,
    input  logic                    rstn,
    input  logic                    cn_req,
    input  logic                    vn_req,
    input  logic [ITER_ADDR_BW-1:0] cn_iter,
    input  logic [ITER_ADDR_BW-1:0] vn_iter,
    output logic                    cn_gnt,
    output logic                    vn_gnt,
    output logic                    rom_en,
    output logic [ROM_ADDR_BW-1:0]  rom_addr,
    output logic                    cn_done,
    output logic                    vn_done,
    output logic                    cn_err,
    output logic                    vn_err,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One extra bit so MAX_ITER == 2^ITER_ADDR_BW still compares correctly.
    localparam logic [ITER_ADDR_BW:0]   MAX_ITER_W = (ITER_ADDR_BW+1)'(MAX_ITER);
    localparam logic [PAGE_ADDR_BW-1:0] LAST_PAGE  = PAGE_ADDR_BW'(BURST_LEN - 1);

    function automatic logic [ROM_ADDR_BW-1:0] make_addr(
        input logic [ITER_ADDR_BW-1:0] iter,
        input logic [PAGE_ADDR_BW-1:0] page
    );
        return ROM_ADDR_BW'({iter, page});
    endfunction

    state_t                  state_q, state_d;
    logic                    owner_vn_q, owner_vn_d;
    logic                    last_vn_q, last_vn_d;
    logic [ITER_ADDR_BW-1:0] iter_q, iter_d;
    logic [PAGE_ADDR_BW-1:0] page_q, page_d;
    logic                    cn_gnt_q, cn_gnt_d;
    logic                    vn_gnt_q, vn_gnt_d;
    logic                    rom_en_q, rom_en_d;
    logic [ROM_ADDR_BW-1:0]  rom_addr_q, rom_addr_d;
    logic                    cn_done_q, cn_done_d;
    logic                    vn_done_q, vn_done_d;
    logic                    cn_err_q, cn_err_d;
    logic                    vn_err_q, vn_err_d;
    logic                    busy_q, busy_d;
    logic                    cn_ok_s, vn_ok_s;

    assign cn_ok_s = cn_req && ({1'b0, cn_iter} < MAX_ITER_W);
    assign vn_ok_s = vn_req && ({1'b0, vn_iter} < MAX_ITER_W);

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        owner_vn_d = owner_vn_q;
        last_vn_d  = last_vn_q;
        iter_d     = iter_q;
        page_d     = page_q;
        cn_gnt_d   = 1'b0;
        vn_gnt_d   = 1'b0;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        cn_done_d  = 1'b0;
        vn_done_d  = 1'b0;
        cn_err_d   = 1'b0;
        vn_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cn_err_d = cn_req && !cn_ok_s;
                vn_err_d = vn_req && !vn_ok_s;
                // CN wins a tie only when VN owned the previous burst.
                if (cn_ok_s && (!vn_ok_s || last_vn_q)) begin
                    state_d    = BURST;
                    owner_vn_d = 1'b0;
                    last_vn_d  = 1'b0;
                    iter_d     = cn_iter;
                    page_d     = '0;
                    cn_gnt_d   = 1'b1;
                    rom_en_d   = 1'b1;
                    rom_addr_d = make_addr(cn_iter, '0);
                end else if (vn_ok_s) begin
                    state_d    = BURST;
                    owner_vn_d = 1'b1;
                    last_vn_d  = 1'b1;
                    iter_d     = vn_iter;
                    page_d     = '0;
                    vn_gnt_d   = 1'b1;
                    rom_en_d   = 1'b1;
                    rom_addr_d = make_addr(vn_iter, '0);
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (page_q == LAST_PAGE) begin
                    state_d   = DONE;
                    page_d    = '0;
                    cn_done_d = !owner_vn_q;
                    vn_done_d = owner_vn_q;
                end else begin
                    page_d     = page_q + PAGE_ADDR_BW'(1);
                    cn_gnt_d   = !owner_vn_q;
                    vn_gnt_d   = owner_vn_q;
                    rom_en_d   = 1'b1;
                    rom_addr_d = make_addr(iter_q, page_q + PAGE_ADDR_BW'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            owner_vn_q <= 1'b0;
            last_vn_q  <= 1'b1;
            iter_q     <= '0;
            page_q     <= '0;
            cn_gnt_q   <= 1'b0;
            vn_gnt_q   <= 1'b0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            cn_done_q  <= 1'b0;
            vn_done_q  <= 1'b0;
            cn_err_q   <= 1'b0;
            vn_err_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_vn_q <= owner_vn_d;
            last_vn_q  <= last_vn_d;
            iter_q     <= iter_d;
            page_q     <= page_d;
            cn_gnt_q   <= cn_gnt_d;
            vn_gnt_q   <= vn_gnt_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            cn_done_q  <= cn_done_d;
            vn_done_q  <= vn_done_d;
            cn_err_q   <= cn_err_d;
            vn_err_q   <= vn_err_d;
            busy_q     <= busy_d;
        end
    end

    assign cn_gnt   = cn_gnt_q;
    assign vn_gnt   = vn_gnt_q;
    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign cn_done  = cn_done_q;
    assign vn_done  = vn_done_q;
    assign cn_err   = cn_err_q;
    assign vn_err   = vn_err_q;
    assign busy     = busy_q;

    ib_rom_rd_arbiter_chk #(
        .ITER_ADDR_BW (ITER_ADDR_BW),
        .PAGE_ADDR_BW (PAGE_ADDR_BW),
        .ROM_ADDR_BW  (ROM_ADDR_BW),
        .BURST_LEN    (BURST_LEN)
    ) u_chk (
        .write_clk (write_clk),
        .rstn      (rstn),
        .cn_gnt    (cn_gnt_q),
        .vn_gnt    (vn_gnt_q),
        .rom_en    (rom_en_q),
        .cn_done   (cn_done_q),
        .vn_done   (vn_done_q),
        .cn_err    (cn_err_q),
        .vn_err    (vn_err_q)
    );

endmodule

// Invariant checker: parameter legality plus grant/pulse exclusivity.
module ib_rom_rd_arbiter_chk #(
    parameter int ITER_ADDR_BW = 5,
    parameter int PAGE_ADDR_BW = 5,
    parameter int ROM_ADDR_BW  = 10,
    parameter int BURST_LEN    = 32
) (
    input logic write_clk,
    input logic rstn,
    input logic cn_gnt,
    input logic vn_gnt,
    input logic rom_en,
    input logic cn_done,
    input logic vn_done,
    input logic cn_err,
    input logic vn_err
);

    if (ROM_ADDR_BW != ITER_ADDR_BW + PAGE_ADDR_BW) begin : g_bad_addr_bw
        $error("ROM_ADDR_BW must equal ITER_ADDR_BW + PAGE_ADDR_BW");
    end
    if (BURST_LEN < 1 || BURST_LEN > (1 << PAGE_ADDR_BW)) begin : g_bad_burst_len
        $error("BURST_LEN out of range for PAGE_ADDR_BW");
    end

    a_gnt_mutex: assert property (@(posedge write_clk) disable iff (!rstn)
        !(cn_gnt && vn_gnt));
    a_en_matches_gnt: assert property (@(posedge write_clk) disable iff (!rstn)
        rom_en == (cn_gnt || vn_gnt));
    a_cn_pulse_excl: assert property (@(posedge write_clk) disable iff (!rstn)
        !(cn_done && cn_err));
    a_vn_pulse_excl: assert property (@(posedge write_clk) disable iff (!rstn)
        !(vn_done && vn_err));

endmodule
